// File: rtl/upc_pkg.sv
// upc_pkg: shared definitions for the UPC serial transmitter.
//   - state_t    : transmitter FSM states (PARITY only exists when
//                  UPC_TX_PARITY_EN is defined)
//   - *_BIT      : bit positions of the fields inside an item record
//   - DATA_BITS  : number of record bits shifted onto the line
// Optional feature macro: UPC_TX_PARITY_EN (adds the even-parity bit).
package upc_pkg;

    localparam int U_BIT     = 3;
    localparam int P_BIT     = 2;
    localparam int C_BIT     = 1;
    localparam int MARK_BIT  = 0;
    localparam int DATA_BITS = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UPC_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef UPC_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] rec);
        return ^rec;
    endfunction
`endif

endpackage

// File: rtl/upc_bit_timer.sv
// upc_bit_timer: counts clock cycles within one serial bit.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   run      in   high while a frame is in flight; low holds the count at 0
//   count    out  current cycle within the bit, 0..CLKS_PER_BIT-1
//   bit_end  out  one-cycle strobe on the last cycle of each bit
module upc_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    output logic [9:0] count,
    output logic       bit_end
);

    // Ten bits cover the full legal range of CLKS_PER_BIT (up to 1023).
    localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);

    assign bit_end = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 10'd1;
        end
    end

endmodule

// File: rtl/upc_serial_tx.sv
// upc_serial_tx: sends one 4-bit item record {U, P, C, mark} as a serial
// frame: start bit (0), mark, C, P, U (LSB first), optional even parity,
// stop bit (1). The line idles high.
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   synchronous active-low reset
//   in_valid    in   in_data holds a record to send
//   in_data     in   record {U, P, C, mark}
//   in_ready    out  high exactly in IDLE; handshake = in_valid & in_ready
//   tx_line     out  registered serial line
//   busy        out  registered, high from start bit through stop bit
//   frame_done  out  registered, one-cycle pulse on last stop-bit cycle
//   state_dbg   out  current FSM state encoding (upc_pkg::state_t)
// Handshake: a record is taken on a rising edge where in_valid and
// in_ready are both high; in_valid in any other cycle is ignored.
// Optional feature macro: UPC_TX_PARITY_EN (adds the even-parity bit).
module upc_serial_tx
    import upc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       tx_line,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] state_dbg
);

    state_t     state;
    logic [3:0] data_q;
    logic [1:0] bit_idx;
    logic [9:0] count;
    logic       bit_end;

    assign in_ready  = (state == IDLE);
    assign state_dbg = state;

    upc_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state != IDLE),
        .count  (count),
        .bit_end(bit_end)
    );

    // The outputs are registered, so each value is loaded on the edge that
    // enters the bit it belongs to. frame_done is raised one cycle before
    // the end of STOP so that it is high during the final stop cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            data_q     <= '0;
            bit_idx    <= '0;
            tx_line    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        bit_idx <= '0;
                        state   <= START;
                        tx_line <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx_line <= data_q[MARK_BIT];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 2'(DATA_BITS - 1)) begin
`ifdef UPC_TX_PARITY_EN
                            state   <= PARITY;
                            tx_line <= even_parity(data_q);
`else
                            state   <= STOP;
                            tx_line <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                            tx_line <= data_q[bit_idx + 2'd1];
                        end
                    end
                end
`ifdef UPC_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        tx_line <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_line <= 1'b1;
                    end else if (count == 10'(CLKS_PER_BIT - 2)) begin
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_line <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upc_serial_tx.sv
// tb_upc_serial_tx: self-checking bench for upc_serial_tx with
// CLKS_PER_BIT=4. Expected line bits per frame are pushed to a queue at
// the handshake and popped bit by bit as the line is sampled on falling
// clock edges. Honours UPC_TX_PARITY_EN to match the RTL build.
module tb_upc_serial_tx;

    localparam int CPB = 4;
`ifdef UPC_TX_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       tx_line;
    logic       busy;
    logic       frame_done;
    logic [2:0] state_dbg;

    logic [0:0] exp_q[$];
    int         n_total = 0;
    int         n_pass  = 0;

    typedef struct {
        logic [3:0] data;
        int         mode;   // 0 normal, 1 keep in_valid high, 2 noise while busy
        logic [6:0] seq;    // bit i = i-th bit sent on the line
    } vec_t;

    vec_t vecs[9];

    upc_serial_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx_line   (tx_line),
        .busy      (busy),
        .frame_done(frame_done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [6:0] model_frame(input logic [3:0] d);
        logic [6:0] s;
        s = '0;
        s[0] = 1'b0;
        s[4:1] = d;
`ifdef UPC_TX_PARITY_EN
        s[5] = ^d;
        s[6] = 1'b1;
`else
        s[5] = 1'b1;
`endif
        return s;
    endfunction

    task automatic check_idle(input string tag);
        check(tx_line === 1'b1,    {tag, "_tx"},         int'(tx_line),    1);
        check(busy === 1'b0,       {tag, "_busy"},       int'(busy),       0);
        check(in_ready === 1'b1,   {tag, "_in_ready"},   int'(in_ready),   1);
        check(frame_done === 1'b0, {tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // Driver + monitor for one frame. Called at a falling edge; returns at
    // the falling edge of the IDLE cycle after the frame (or after the
    // post-abort observation window when abort_bit >= 0).
    task automatic run_frame(input logic [3:0] d, input logic [6:0] seq,
                             input int mode, input int abort_bit);
        int   wait_n;
        logic exp_bit;
        bit   tx_ok, busy_ok, rdy_ok, fd_ok, fd_seen, line_hi;
        int   tx_act, fd_act;
        in_data  = d;
        in_valid = 1'b1;
        wait_n   = 0;
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) begin
            check(1'b0, "handshake_timeout", wait_n, 0);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < NB; i++) exp_q.push_back(seq[i]);
        busy_ok = 1; rdy_ok = 1; fd_ok = 1; fd_act = 0;
        for (int b = 0; b < NB; b++) begin
            exp_bit = exp_q.pop_front();
            tx_ok   = 1;
            tx_act  = int'(exp_bit);
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx_line !== exp_bit) begin
                    tx_ok  = 0;
                    tx_act = int'(tx_line);
                end
                if (busy !== 1'b1) busy_ok = 0;
                if (in_ready !== 1'b0) rdy_ok = 0;
                if (frame_done !== ((b == NB - 1) && (c == CPB - 1))) begin
                    fd_ok  = 0;
                    fd_act = b * CPB + c + 1;
                end
                if (mode == 0 && b == 0 && c == 0) in_valid = 1'b0;
                if (mode == 2) begin
                    if (b == NB - 1 && c == CPB - 1) begin
                        in_valid = 1'b0;
                    end else begin
                        in_valid = 1'($urandom_range(0, 1));
                        in_data  = 4'($urandom_range(0, 15));
                    end
                end
                if (b == abort_bit && c == 1) begin
                    check(tx_ok, "tx_bit_pre_abort", tx_act, int'(exp_bit));
                    reset_n = 1'b0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    check_idle("abort");
                    fd_seen = 0;
                    line_hi = 1;
                    for (int k = 0; k < 40; k++) begin
                        @(negedge clk);
                        if (frame_done !== 1'b0) fd_seen = 1;
                        if (tx_line !== 1'b1) line_hi = 0;
                    end
                    check(!fd_seen, "abort_no_frame_done", int'(fd_seen), 0);
                    check(line_hi,  "abort_line_high",     int'(line_hi), 1);
                    exp_q.delete();
                    return;
                end
            end
            check(tx_ok, $sformatf("tx_bit%0d_d%0h", b, d), tx_act, int'(exp_bit));
        end
        check(busy_ok, "busy_in_frame",     int'(busy_ok), 1);
        check(rdy_ok,  "in_ready_low_busy", int'(rdy_ok),  1);
        check(fd_ok,   "frame_done_cycle",  fd_act,        NB * CPB);
        @(negedge clk);
        check_idle("gap");
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;

        // Vector table: spec frames written out by hand, others from the model.
`ifdef UPC_TX_PARITY_EN
        vecs[0] = '{4'b1010, 0, 7'b1010100};
        vecs[1] = '{4'b0111, 0, 7'b1101110};
`else
        vecs[0] = '{4'b1010, 0, 7'b0110100};
        vecs[1] = '{4'b0111, 0, 7'b0101110};
`endif
        vecs[2] = '{4'h0, 0, model_frame(4'h0)};
        vecs[3] = '{4'hF, 0, model_frame(4'hF)};
        vecs[4] = '{4'h5, 1, model_frame(4'h5)};
        vecs[5] = '{4'hA, 0, model_frame(4'hA)};
        vecs[6] = '{4'h3, 2, model_frame(4'h3)};
        for (int i = 7; i < 9; i++) begin
            vecs[i].data = 4'($urandom_range(0, 15));
            vecs[i].mode = 0;
            vecs[i].seq  = model_frame(vecs[i].data);
        end

        repeat (3) @(negedge clk);
        check_idle("reset");
        check(state_dbg === 3'd0, "reset_state", int'(state_dbg), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].data, vecs[i].seq, vecs[i].mode, -1);
        end
        // After the noise frame nothing further may have been accepted.
        @(negedge clk);
        check_idle("after_noise");

        // Reset during DATA bit 2 (line bit index 3), then a clean recovery frame.
        run_frame(4'hD, model_frame(4'hD), 0, 3);
        run_frame(4'h9, model_frame(4'h9), 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/upc_serial_tx.md
UPC_SERIAL_TX -- requirements
Module: upc_serial_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 8, SHALL set the clock cycles per serial bit; legal range 2..1023.
- REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-003: reset_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
- REQ-004: in_valid  input  1  SHALL mean in_data holds an item record to send.
- REQ-005: in_data  input  4  SHALL be the item record {U, P, C, mark}: bit3=U, bit2=P, bit1=C, bit0=secret mark.
- REQ-006: in_ready  output  1  SHALL be high exactly when the block accepts a record this cycle.
- REQ-007: tx_line  output  1  SHALL be the serial line; it idles high.
- REQ-008: busy  output  1  SHALL be high while a frame is on the line, from the start bit through the stop bit.
- REQ-009: frame_done  output  1  SHALL pulse high for one cycle on the last cycle of the stop bit.

Function
- REQ-010: A handshake SHALL occur when in_valid and in_ready are both high on a clock edge; in_data is latched on that edge.
- REQ-011: in_ready SHALL equal (state == IDLE); in_valid in any other state is ignored and does not queue.
- REQ-012: FSM states SHALL be IDLE, START, DATA, PARITY and STOP; IDLE drives tx_line=1, and every other state lasts CLKS_PER_BIT cycles.
- REQ-013: Transitions SHALL be:
  - IDLE->START on handshake;
  - START->DATA;
  - DATA->PARITY after 4 bits, when parity is compiled in; otherwise DATA->STOP;
  - PARITY->STOP;
  - STOP->IDLE.
- REQ-014: START SHALL drive tx_line=0, beginning the cycle after the handshake (1-cycle latency).
- REQ-015: DATA SHALL send the latched bits LSB first: mark, C, P, U.
- REQ-016: PARITY SHALL send even parity, the XOR of the 4 latched bits.
- REQ-017: STOP SHALL drive tx_line=1.
- REQ-018: A bit-cycle counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; a 2-bit index SHALL select the data bit.
- REQ-019: Frame length SHALL be 7*CLKS_PER_BIT cycles with parity and 6*CLKS_PER_BIT without.
- REQ-020: With in_valid held high, back-to-back frames SHALL be separated by exactly one IDLE cycle with tx_line=1.
- REQ-021: Changes on in_data after the handshake SHALL NOT affect the frame in flight.
- REQ-022: tx_line, busy and frame_done SHALL be registered outputs (no combinational path from inputs).

Reset
- REQ-023: While reset_n is low, the block SHALL enter IDLE on the next edge, with:
  - tx_line=1, busy=0, frame_done=0, in_ready=1 (after the edge);
  - counters=0, latched data=0.
- REQ-024: Reset asserted mid-frame SHALL abort the frame; tx_line SHALL be high on the cycle after the reset edge, and frame_done SHALL NOT pulse.

Configuration
- REQ-025: Macro UPC_TX_PARITY_EN defined SHALL compile in the PARITY state and the even-parity bit (7-bit frame).
- REQ-026: Without UPC_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, DATA SHALL go directly to STOP, and the frame is 6 bits.

Structure
- REQ-027: Shared package upc_pkg SHALL hold:
  - the FSM state enum;
  - field-index constants (U_BIT=3, P_BIT=2, C_BIT=1, MARK_BIT=0);
  - DATA_BITS=4.
- REQ-028: One sub-module, upc_bit_timer, SHALL implement the CLKS_PER_BIT counter and emit a one-cycle bit_end strobe; it is cleared on reset and at IDLE.

Verification
- REQ-029: Parity on, CLKS_PER_BIT=4, in_data=4'b1010 handshake at cycle 0 -> tx_line 0,0,1,0,1,0,1 per 4-cycle bit from cycle 1; frame_done at cycle 28; in_ready high at cycle 29.
- REQ-030: Parity on, in_data=4'b0111 -> parity bit 1, data bits 1,1,1,0.
- REQ-031: Parity off, CLKS_PER_BIT=4, in_data=4'b0111 -> tx_line 0,1,1,1,0,1; frame_done at cycle 24.
- REQ-032: in_valid held high with records 4'h5 then 4'hA -> two frames separated by exactly one high IDLE cycle; the second frame carries 4'hA.
- REQ-033: reset_n low for 1 cycle during DATA bit 2 -> tx_line=1, busy=0, in_ready=1 on the next cycle; no frame_done pulse.
- REQ-034: Toggle in_data and pulse in_valid during busy -> frame bits unchanged, no extra handshake, in_ready=0 throughout.
